// File: rtl/core_seq_pkg.sv
// Shared types and constants for the core_seq multi-cycle sequencer.
package core_seq_pkg;

  localparam int TIMEOUT_W_DEF = 8;

  typedef enum logic [2:0] {
    RESET_WAIT = 3'd0,
    FETCH      = 3'd1,
    DECODE     = 3'd2,
    EXEC       = 3'd3,
    MEM        = 3'd4,
    WB         = 3'd5,
    HALT       = 3'd6,
    ERR        = 3'd7
  } seq_state_t;

  // Number of consecutive un-acked request cycles that trips the watchdog.
  function automatic int wdog_limit(input int width);
    return (1 << width) - 1;
  endfunction

endpackage

// File: rtl/core_seq_wdog.sv
// Bus watchdog: counts un-acked request cycles, flags expiry on the limit-th one.
module core_seq_wdog
  import core_seq_pkg::*;
#(
  parameter int TIMEOUT_W = TIMEOUT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic cnt_en,
  output logic expired
);

  localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'(wdog_limit(TIMEOUT_W) - 1);

  logic [TIMEOUT_W-1:0] cnt;

  // Expiry is combinational so the FSM leaves on the cycle the limit is hit.
  assign expired = cnt_en && (cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (cnt_en) begin
      cnt <= cnt + TIMEOUT_W'(1);
    end
  end

endmodule

// File: rtl/core_seq.sv
// Multi-cycle fetch/decode/exec/mem/wb sequencer for the RV64 core.
// Define CORE_SEQ_PERF_EN to add the perf_cycle/perf_instret counters.
module core_seq
  import core_seq_pkg::*;
#(
  parameter int TIMEOUT_W = TIMEOUT_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
`ifdef CORE_SEQ_PERF_EN
  output logic [63:0] perf_cycle,
  output logic [63:0] perf_instret,
`endif
  output logic        ibus_req,
  input  logic        ibus_ack,
  output logic        dbus_req,
  output logic        dbus_we,
  input  logic        dbus_ack,
  input  logic        dec_dm_r,
  input  logic        dec_dm_w,
  input  logic        dec_rf_w,
  input  logic        freeze,
  output logic        idu_valid,
  output logic        dstall,
  output logic        rf_we,
  output logic        pc_we,
  output logic        halted,
  output logic        bus_err
);

  seq_state_t state;
  seq_state_t state_next;
  logic       wd_cnt_en;
  logic       wd_clr;
  logic       wd_expired;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RESET_WAIT;
    end else begin
      state <= state_next;
    end
  end

  // An ack in the limit cycle takes priority over the watchdog.
  always_comb begin
    state_next = state;
    unique case (state)
      RESET_WAIT: state_next = FETCH;
      FETCH: begin
        if (ibus_ack)        state_next = DECODE;
        else if (wd_expired) state_next = ERR;
      end
      DECODE: state_next = EXEC;
      EXEC:   state_next = (dec_dm_r || dec_dm_w) ? MEM : WB;
      MEM: begin
        if (dbus_ack)        state_next = WB;
        else if (wd_expired) state_next = ERR;
      end
      WB:     state_next = freeze ? HALT : FETCH;
      HALT:   if (!freeze) state_next = FETCH;
      ERR:    state_next = ERR;
      default: state_next = ERR;
    endcase
  end

  // Outputs decode straight from state so reset forces them low at once.
  assign ibus_req  = (state == FETCH);
  assign idu_valid = (state == DECODE);
  assign dbus_req  = (state == MEM);
  assign dbus_we   = (state == MEM) && dec_dm_w;
  assign pc_we     = (state == WB);
  assign rf_we     = (state == WB) && dec_rf_w;
  assign dstall    = (state == WB) && dec_dm_r && !dec_dm_w;
  assign halted    = (state == HALT);
  assign bus_err   = (state == ERR);

  assign wd_cnt_en = (ibus_req && !ibus_ack) || (dbus_req && !dbus_ack);
  assign wd_clr    = !wd_cnt_en || (state_next != state);

  core_seq_wdog #(
    .TIMEOUT_W (TIMEOUT_W)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (wd_clr),
    .cnt_en  (wd_cnt_en),
    .expired (wd_expired)
  );

`ifdef CORE_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_cycle   <= '0;
      perf_instret <= '0;
    end else begin
      if (!(state inside {RESET_WAIT, HALT, ERR})) perf_cycle <= perf_cycle + 64'd1;
      if (state == WB) perf_instret <= perf_instret + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_core_seq.sv
// Scoreboard bench for core_seq: randomized instructions, per-commit checks.
module tb_core_seq;

  localparam int TW    = 4;
  localparam int LIMIT = (1 << TW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ibus_ack = 1'b0, dbus_ack = 1'b0;
  logic dec_dm_r = 1'b0, dec_dm_w = 1'b0, dec_rf_w = 1'b0, freeze = 1'b0;
  logic ibus_req, dbus_req, dbus_we, idu_valid, dstall, rf_we, pc_we, halted, bus_err;
`ifdef CORE_SEQ_PERF_EN
  logic [63:0] perf_cycle, perf_instret;
`endif

  core_seq #(.TIMEOUT_W(TW)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef CORE_SEQ_PERF_EN
    .perf_cycle   (perf_cycle),
    .perf_instret (perf_instret),
`endif
    .ibus_req  (ibus_req),
    .ibus_ack  (ibus_ack),
    .dbus_req  (dbus_req),
    .dbus_we   (dbus_we),
    .dbus_ack  (dbus_ack),
    .dec_dm_r  (dec_dm_r),
    .dec_dm_w  (dec_dm_w),
    .dec_rf_w  (dec_rf_w),
    .freeze    (freeze),
    .idu_valid (idu_valid),
    .dstall    (dstall),
    .rf_we     (rf_we),
    .pc_we     (pc_we),
    .halted    (halted),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;

  // Expected view of one instruction, as counts of output-active cycles.
  typedef struct {
    int rf;
    int ds;
    int fetch;
    int mem;
    int dwe;
    int halt;
    int idle;
    int total;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   pre_halt = 0;
  int   pre_idle = 0;

  task automatic checkOutput(input string name, input longint act, input longint req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic rbit();
    return 1'($urandom());
  endfunction

  // Monitor: accumulates output activity and scores it at every commit.
  int     m_cyc, m_ireq, m_idu, m_dreq, m_dwe, m_halt, m_stray, m_commits;
  longint m_active;
  exp_t   m_e;

  always @(negedge clk) begin
    if (!rst) begin
      m_cyc = 0; m_ireq = 0; m_idu = 0; m_dreq = 0; m_dwe = 0;
      m_halt = 0; m_stray = 0; m_commits = 0; m_active = 0;
    end else begin
      m_cyc++;
      if (ibus_req)  m_ireq++;
      if (idu_valid) m_idu++;
      if (dbus_req)  m_dreq++;
      if (dbus_we)   m_dwe++;
      if (halted)    m_halt++;
      if (!pc_we && (rf_we || dstall)) m_stray++;
      if (pc_we) begin
        checkOutput("commit_expected", longint'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          m_e = exp_q.pop_front();
          checkOutput("wb_rf_we",    rf_we,   m_e.rf);
          checkOutput("wb_dstall",   dstall,  m_e.ds);
          checkOutput("fetch_cycles", m_ireq, m_e.fetch);
          checkOutput("idu_strobes",  m_idu,  1);
          checkOutput("mem_cycles",   m_dreq, m_e.mem);
          checkOutput("store_cycles", m_dwe,  m_e.dwe);
          checkOutput("halt_cycles",  m_halt, m_e.halt);
          checkOutput("stray_enables", m_stray, 0);
          checkOutput("instr_latency", m_cyc, m_e.total);
`ifdef CORE_SEQ_PERF_EN
          checkOutput("perf_instret", perf_instret, m_commits);
          checkOutput("perf_cycle", perf_cycle, m_active + m_e.total - m_e.idle - 1);
`endif
          m_active += m_e.total - m_e.idle;
        end
        m_commits++;
        m_cyc = 0; m_ireq = 0; m_idu = 0; m_dreq = 0; m_dwe = 0; m_halt = 0; m_stray = 0;
      end
    end
  end

  // Drives one instruction starting in FETCH; expectations come from the
  // stage latencies: fetch+1, decode 1, exec 1, mem waits+1 if any, wb 1.
  task automatic applyStimulus(input int fw, input int mw, input logic r, input logic w,
                               input logic rf, input logic frz, input int h);
    exp_t e;
    e.rf    = int'(rf);
    e.ds    = int'(r && !w);
    e.fetch = fw + 1;
    e.mem   = (r || w) ? mw + 1 : 0;
    e.dwe   = w ? mw + 1 : 0;
    e.halt  = pre_halt;
    e.idle  = pre_idle;
    e.total = pre_idle + (fw + 1) + 2 + e.mem + 1;
    exp_q.push_back(e);
    dec_dm_r = r; dec_dm_w = w; dec_rf_w = rf;
    for (int i = 0; i < fw; i++) begin
      ibus_ack = 1'b0; dbus_ack = rbit(); freeze = rbit();
      @(posedge clk); #1;
    end
    ibus_ack = 1'b1; dbus_ack = rbit(); freeze = rbit();
    @(posedge clk); #1;
    ibus_ack = rbit(); dbus_ack = rbit();
    @(posedge clk); #1;
    ibus_ack = rbit(); dbus_ack = rbit(); freeze = rbit();
    @(posedge clk); #1;
    if (r || w) begin
      for (int i = 0; i < mw; i++) begin
        dbus_ack = 1'b0; ibus_ack = rbit(); freeze = rbit();
        @(posedge clk); #1;
      end
      dbus_ack = 1'b1; ibus_ack = rbit(); freeze = rbit();
      @(posedge clk); #1;
    end
    ibus_ack = rbit(); dbus_ack = rbit(); freeze = frz;
    @(posedge clk); #1;
    if (frz) begin
      for (int i = 1; i < h; i++) begin
        ibus_ack = rbit(); dbus_ack = rbit();
        @(posedge clk); #1;
      end
      freeze = 1'b0;
      @(posedge clk); #1;
    end
    ibus_ack = 1'b0; dbus_ack = 1'b0;
    pre_halt = frz ? h : 0;
    pre_idle = pre_halt;
  endtask

  task automatic releaseReset();
    rst = 1'b1;
    @(posedge clk); #1;
    pre_halt = 0;
    pre_idle = 1;
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL global_timeout: got running, expected finished");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    int fw, mw, h;
    logic r, w, rf, frz;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_ibus_req", ibus_req, 0);
    checkOutput("rst_dbus_req", dbus_req, 0);
    checkOutput("rst_pc_we",    pc_we,    0);
    checkOutput("rst_halted",   halted,   0);
    checkOutput("rst_bus_err",  bus_err,  0);
`ifdef CORE_SEQ_PERF_EN
    checkOutput("rst_perf_cycle", perf_cycle, 0);
`endif
    releaseReset();

    // Directed: plain ALU op, load, store, load+store, freeze, ack-at-limit.
    applyStimulus(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    applyStimulus(0, 3, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    applyStimulus(0, 1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    applyStimulus(1, 2, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    applyStimulus(0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 3);
    applyStimulus(LIMIT - 1, LIMIT - 1, 1'b1, 1'b0, 1'b1, 1'b1, 1);

    for (int n = 0; n < 40; n++) begin
      fw  = ($urandom_range(0, 7) == 0) ? LIMIT - 1 : int'($urandom_range(0, 3));
      mw  = ($urandom_range(0, 7) == 0) ? LIMIT - 1 : int'($urandom_range(0, 3));
      r   = rbit(); w = rbit(); rf = rbit();
      frz = ($urandom_range(0, 4) == 0);
      h   = int'($urandom_range(1, 3));
      applyStimulus(fw, mw, r, w, rf, frz, h);
    end

    // Reset in the middle of a load's memory phase.
    dec_dm_r = 1'b1; dec_dm_w = 1'b0; dec_rf_w = 1'b1; ibus_ack = 1'b1;
    @(posedge clk); #1;
    ibus_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    dbus_ack = 1'b0;
    @(posedge clk); #1;
    checkOutput("mid_mem_req", dbus_req, 1);
    rst = 1'b0;
    #1;
    checkOutput("abort_dbus_req", dbus_req, 0);
    checkOutput("abort_pc_we",    pc_we,    0);
    checkOutput("abort_rf_we",    rf_we,    0);
`ifdef CORE_SEQ_PERF_EN
    checkOutput("abort_perf_instret", perf_instret, 0);
`endif
    @(posedge clk); #1;
    releaseReset();
    applyStimulus(0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    applyStimulus(2, 1, 1'b1, 1'b0, 1'b1, 1'b0, 0);

    // Fetch that is never acked trips the watchdog after LIMIT cycles.
    ibus_ack = 1'b0; dbus_ack = 1'b0; freeze = 1'b0;
    for (int k = 1; k <= LIMIT; k++) begin
      @(negedge clk);
      checkOutput("tmo_req_live", ibus_req, 1);
      checkOutput("tmo_err_early", bus_err, 0);
    end
    @(negedge clk);
    checkOutput("tmo_bus_err",  bus_err,  1);
    checkOutput("tmo_req_drop", ibus_req, 0);
    @(posedge clk); #1;
    ibus_ack = 1'b1; dbus_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("err_sticky",   bus_err,  1);
      checkOutput("err_no_req",   ibus_req, 0);
      checkOutput("err_no_pc_we", pc_we,    0);
    end
    #2;
    rst = 1'b0;
    #1;
    checkOutput("err_cleared", bus_err, 0);
    ibus_ack = 1'b0; dbus_ack = 1'b0;
    @(posedge clk); #1;

    checkOutput("queue_drained", exp_q.size(), 0);
    $display("[TB] run complete");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
